// File: rtl/regfile_wb_ctrl_if.sv
// Bus bundle between the write-back controller and its neighbours
// (ALU/LSU results, issue tracking, decode read side, regfile write port).
interface regfile_wb_ctrl_if #(
   parameter int unsigned DATA_W = 32
);
   logic              alu_valid;
   logic [4:0]        alu_addr;
   logic [DATA_W-1:0] alu_data;
   logic              lsu_valid;
   logic              lsu_ready;
   logic [4:0]        lsu_addr;
   logic [DATA_W-1:0] lsu_data;
   logic              issue_valid;
   logic [4:0]        issue_addr;
   logic [4:0]        rd_addr1;
   logic [4:0]        rd_addr2;
   logic [DATA_W-1:0] rf_data1;
   logic [DATA_W-1:0] rf_data2;
   logic [DATA_W-1:0] byp_data1;
   logic [DATA_W-1:0] byp_data2;
   logic              stall;
   logic              RegWrite;
   logic [4:0]        WriteAddr;
   logic [DATA_W-1:0] WriteData;

   modport slave (
      input  alu_valid, alu_addr, alu_data,
      input  lsu_valid, lsu_addr, lsu_data,
      input  issue_valid, issue_addr,
      input  rd_addr1, rd_addr2, rf_data1, rf_data2,
      output lsu_ready, byp_data1, byp_data2, stall,
      output RegWrite, WriteAddr, WriteData
   );

   modport master (
      output alu_valid, alu_addr, alu_data,
      output lsu_valid, lsu_addr, lsu_data,
      output issue_valid, issue_addr,
      output rd_addr1, rd_addr2, rf_data1, rf_data2,
      input  lsu_ready, byp_data1, byp_data2, stall,
      input  RegWrite, WriteAddr, WriteData
   );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Regfile write-side controller: ALU/LSU result merge, LSU FIFO, pending scoreboard.
// Optional macro REGFILE_WB_BYPASS_EN forwards the in-flight write to decode operands.
module regfile_wb_ctrl #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DATA_W     = 32
) (
   input logic              clk,
   input logic              reset_n,
   regfile_wb_ctrl_if.slave bus
);
   localparam int unsigned AW    = 5;
   localparam int unsigned NREG  = 32;
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [AW-1:0]     fifo_addr_q [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rdy_en_q;

   logic              wen_q, wen_d;
   logic [AW-1:0]     waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [NREG-1:0]   pending_q, pending_d;

   logic push, pop, full;
   logic [AW-1:0]     head_addr;
   logic [DATA_W-1:0] head_data;
   logic pend1, pend2;

   assign full      = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign push      = bus.lsu_valid && bus.lsu_ready;
   // An entry pushed this cycle is not visible to pop until it has been stored.
   assign pop       = !bus.alu_valid && (cnt_q != '0);
   assign head_addr = fifo_addr_q[rd_ptr_q];
   assign head_data = fifo_data_q[rd_ptr_q];

   assign bus.lsu_ready = rdy_en_q && !full;
   assign bus.RegWrite  = wen_q;
   assign bus.WriteAddr = waddr_q;
   assign bus.WriteData = wdata_q;

   // FIFO pointer and occupancy next state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Write-port arbitration: ALU first, then FIFO head; register 0 is consumed silently
   always_comb begin
      wen_d   = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (bus.alu_valid) begin
         if (bus.alu_addr != '0) begin
            wen_d   = 1'b1;
            waddr_d = bus.alu_addr;
            wdata_d = bus.alu_data;
         end
      end else if (pop) begin
         if (head_addr != '0) begin
            wen_d   = 1'b1;
            waddr_d = head_addr;
            wdata_d = head_data;
         end
      end
   end

   // Scoreboard: clear on commit, then set so a same-edge issue wins
   always_comb begin
      pending_d = pending_q;
      if (wen_q) pending_d[waddr_q] = 1'b0;
      if (bus.issue_valid && (bus.issue_addr != '0)) pending_d[bus.issue_addr] = 1'b1;
   end

`ifdef REGFILE_WB_BYPASS_EN
   logic hit1, hit2;
   assign hit1 = wen_q && (waddr_q == bus.rd_addr1) && (bus.rd_addr1 != '0);
   assign hit2 = wen_q && (waddr_q == bus.rd_addr2) && (bus.rd_addr2 != '0);
   assign pend1 = (bus.rd_addr1 != '0) && pending_q[bus.rd_addr1] && !hit1;
   assign pend2 = (bus.rd_addr2 != '0) && pending_q[bus.rd_addr2] && !hit2;
   assign bus.byp_data1 = hit1 ? wdata_q : bus.rf_data1;
   assign bus.byp_data2 = hit2 ? wdata_q : bus.rf_data2;
`else
   assign pend1 = (bus.rd_addr1 != '0) && pending_q[bus.rd_addr1];
   assign pend2 = (bus.rd_addr2 != '0) && pending_q[bus.rd_addr2];
   assign bus.byp_data1 = bus.rf_data1;
   assign bus.byp_data2 = bus.rf_data2;
`endif

   assign bus.stall = pend1 || pend2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         rdy_en_q  <= 1'b0;
         wen_q     <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         pending_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         rdy_en_q  <= 1'b1;
         wen_q     <= wen_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         pending_q <= pending_d;
      end
   end

   // Payload storage needs no reset; occupancy alone defines validity
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= bus.lsu_addr;
         fifo_data_q[wr_ptr_q] <= bus.lsu_data;
      end
   end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: directed plan items plus random traffic
// against a queue-based model of the write-back rules.
module tb_regfile_wb_ctrl;
   localparam int unsigned DEPTH = 4;
`ifdef REGFILE_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   regfile_wb_ctrl_if #(.DATA_W(32)) bus ();
   regfile_wb_ctrl #(.FIFO_DEPTH(DEPTH), .DATA_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus.slave)
   );

   int n_chk = 0;
   int n_pass = 0;

   wr_t        mq[$];
   wr_t        expq[$];
   bit [31:0]  mpend;
   bit         mw_v;
   logic [4:0] mw_a;
   logic [31:0] mw_d;
   bit         rel;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Monitor: each committed write must match the oldest expected write
   always @(negedge clk) begin
      if (reset_n && bus.RegWrite === 1'b1) begin
         if (expq.size() == 0) begin
            chk("unexpected_write", 32'(bus.WriteAddr), 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = expq.pop_front();
            chk("write_addr", 32'(bus.WriteAddr), 32'(e.a));
            chk("write_data", bus.WriteData, e.d);
         end
      end
   end

   task automatic model_clear();
      mq.delete();
      expq.delete();
      mpend = '0;
      mw_v  = 1'b0;
      mw_a  = '0;
      mw_d  = '0;
   endtask

   task automatic step(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit lv, input logic [4:0] la, input logic [31:0] ld,
                       input bit iv, input logic [4:0] ia,
                       input logic [4:0] r1, input logic [4:0] r2, output bit acc);
      bit exp_rdy, s1, s2, h1, h2, nv;
      logic [4:0] na;
      logic [31:0] nd, rf1, rf2;
      wr_t e;
      rf1 = $urandom;
      rf2 = $urandom;
      bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
      bus.lsu_valid = lv; bus.lsu_addr = la; bus.lsu_data = ld;
      bus.issue_valid = iv; bus.issue_addr = ia;
      bus.rd_addr1 = r1; bus.rd_addr2 = r2;
      bus.rf_data1 = rf1; bus.rf_data2 = rf2;
      #1;
      exp_rdy = rel && (mq.size() < DEPTH);
      h1 = BYP && mw_v && (mw_a == r1) && (r1 != 0);
      h2 = BYP && mw_v && (mw_a == r2) && (r2 != 0);
      s1 = (r1 != 0) && mpend[r1] && !h1;
      s2 = (r2 != 0) && mpend[r2] && !h2;
      chk("lsu_ready", 32'(bus.lsu_ready), 32'(exp_rdy));
      chk("stall", 32'(bus.stall), 32'(s1 || s2));
      chk("byp_data1", bus.byp_data1, h1 ? mw_d : rf1);
      chk("byp_data2", bus.byp_data2, h2 ? mw_d : rf2);
      acc = lv && exp_rdy;
      nv = 1'b0; na = mw_a; nd = mw_d;
      if (av) begin
         if (aa != 0) begin nv = 1'b1; na = aa; nd = ad; end
      end else if (mq.size() > 0) begin
         e = mq.pop_front();
         if (e.a != 0) begin nv = 1'b1; na = e.a; nd = e.d; end
      end
      if (mw_v) mpend[mw_a] = 1'b0;
      if (iv && ia != 0) mpend[ia] = 1'b1;
      if (acc) begin e.a = la; e.d = ld; mq.push_back(e); end
      if (nv) begin e.a = na; e.d = nd; expq.push_back(e); end
      mw_v = nv; mw_a = na; mw_d = nd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
      bit acc;
      step(0, 0, 0, 0, 0, 0, 0, 0, r1, r2, acc);
   endtask

   initial begin
      bit acc;
      logic [4:0] oq[$];
      model_clear();
      rel = 1'b0;
      bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_data = 0;
      bus.lsu_valid = 0; bus.lsu_addr = 0; bus.lsu_data = 0;
      bus.issue_valid = 0; bus.issue_addr = 0;
      bus.rd_addr1 = 0; bus.rd_addr2 = 0; bus.rf_data1 = 0; bus.rf_data2 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_lsu_ready", 32'(bus.lsu_ready), 32'd0);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk);
      #1;
      rel = 1'b1;

      // Reset mid-write with three entries buffered and r4 pending
      step(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, acc);
      step(1, 20, 32'hA0, 1, 4, 32'hB0, 0, 0, 4, 0, acc);
      step(1, 21, 32'hA1, 1, 21, 32'hB1, 0, 0, 4, 0, acc);
      step(1, 22, 32'hA2, 1, 22, 32'hB2, 0, 0, 4, 0, acc);
      reset_n = 1'b0;
      #1;
      chk("rst_regwrite", 32'(bus.RegWrite), 32'd0);
      chk("rst_waddr", 32'(bus.WriteAddr), 32'd0);
      chk("rst_wdata", bus.WriteData, 32'd0);
      chk("rst_lsu_ready", 32'(bus.lsu_ready), 32'd0);
      model_clear();
      rel = 1'b0;
      bus.alu_valid = 0; bus.lsu_valid = 0;
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk);
      #1;
      rel = 1'b1;
      idle(4, 0);
      idle(0, 0);

      // ALU write, then ALU to r0
      step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, acc);
      step(1, 0, 32'h1234, 0, 0, 0, 0, 0, 5, 0, acc);
      #0 chk("r0_no_write", 32'(bus.RegWrite), 32'd0);
      idle(0, 0);

      // Arbitration: LSU entry waits behind three ALU results
      step(1, 1, 32'h1, 1, 7, 32'h11, 0, 0, 0, 0, acc);
      step(1, 2, 32'h2, 0, 0, 0, 0, 0, 0, 0, acc);
      step(1, 3, 32'h3, 0, 0, 0, 0, 0, 0, 0, acc);
      repeat (3) idle(0, 0);

      // FIFO full with ALU holding the port
      for (int i = 0; i < 5; i++)
         step(1, 5'(16 + i), 32'(i), 1, 5'(10 + i), 32'hF0 + 32'(i), 0, 0, 0, 0, acc);
      repeat (6) idle(0, 0);

      // Scoreboard on r9, then issue to r0
      step(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, acc);
      repeat (3) idle(9, 0);
      step(0, 0, 0, 1, 9, 32'h9999, 0, 0, 9, 0, acc);
      repeat (4) idle(9, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, acc);
      idle(0, 0);

      // Same-edge set/clear on r12
      step(1, 12, 32'hC12, 0, 0, 0, 0, 0, 0, 12, acc);
      step(0, 0, 0, 0, 0, 0, 1, 12, 0, 12, acc);
      repeat (3) idle(0, 12);
      step(0, 0, 0, 1, 12, 32'h1212, 0, 0, 0, 12, acc);
      repeat (4) idle(0, 12);

      // Random traffic: issued ops return later through the LSU
      for (int c = 0; c < 1500; c++) begin
         bit av, lv, iv;
         logic [4:0] aa, ia, la;
         av = ($urandom_range(0, 99) < 40);
         aa = 5'($urandom_range(0, 31));
         iv = 1'b0; ia = 0;
         if ($urandom_range(0, 99) < 30) begin
            ia = 5'($urandom_range(1, 15));
            iv = !mpend[ia];
         end
         lv = (oq.size() > 0) && ($urandom_range(0, 99) < 50);
         la = lv ? oq[0] : 5'($urandom_range(0, 31));
         step(av, aa, $urandom, lv, la, $urandom, iv, ia,
              5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), acc);
         if (acc) void'(oq.pop_front());
         if (iv) oq.push_back(ia);
      end

      repeat (12) idle(0, 0);
      chk("drain_expq_empty", 32'(expq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Write-side controller for the 32x32 register file; owns and drives the regfile write port (RegWrite/WriteAddr/WriteData).
- Merges single-cycle ALU results with long-latency LSU/mult-div results, buffering the latter in a small FIFO.
- Keeps a per-register pending scoreboard that raises a read stall for the decode stage until the data has been written into the register file.

Parameters:
- FIFO_DEPTH, 4, LSU result FIFO entries; power of 2, minimum 2.
- DATA_W, 32, result and regfile data width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- alu_valid  in  1  ALU result present this cycle; always accepted, no backpressure.
- alu_addr  in  5  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- lsu_valid  in  1  long-latency result offered.
- lsu_ready  out  1  FIFO can accept; transfer when lsu_valid && lsu_ready.
- lsu_addr  in  5  long-latency destination register.
- lsu_data  in  DATA_W  long-latency result.
- issue_valid  in  1  long-latency op issued; marks its destination pending.
- issue_addr  in  5  destination of the issued op.
- rd_addr1  in  5  decode rs address.
- rd_addr2  in  5  decode rt address.
- rf_data1  in  DATA_W  regfile ReadData1.
- rf_data2  in  DATA_W  regfile ReadData2.
- byp_data1  out  DATA_W  operand 1 to decode.
- byp_data2  out  DATA_W  operand 2 to decode.
- stall  out  1  a source operand is pending.
- RegWrite  out  1  registered regfile write enable.
- WriteAddr  out  5  registered write address.
- WriteData  out  DATA_W  registered write data.

Behaviour:
- Reset (reset_n low, asynchronous): FIFO emptied; pending[31:0] = 0; RegWrite = 0; WriteAddr = 0; WriteData = 0. lsu_ready is held at 0 while reset_n is low; it returns to 1 on the first cycle after release.
- Write port outputs are registered; latency from the input cycle to the regfile write edge is 2 edges:
  - edge N: result registered onto RegWrite/WriteAddr/WriteData.
  - edge N+1: regfile writes the data.
- Arbitration each cycle:
  - If alu_valid: the ALU result is registered to the write port and the FIFO head is held.
  - Else if the FIFO is not empty: the head is popped and registered.
  - Else: RegWrite <= 0, and WriteAddr/WriteData hold their previous values.
- Register 0:
  - Any selected source with addr 0 still wins arbitration and is consumed (ALU slot used, FIFO entry popped).
  - It produces RegWrite = 0 for that cycle.
- FIFO:
  - lsu_ready = !full.
  - A simultaneous push and pop when full is not allowed (ready is already low).
  - A push and pop in the same cycle when not empty keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - A push into an empty FIFO is not popped in the same cycle: minimum FIFO-to-port latency is 1 cycle of storage plus the registered port.
- Scoreboard:
  - pending[issue_addr] is set on an edge with issue_valid && issue_addr != 0.
  - pending[WriteAddr] is cleared on an edge where RegWrite == 1; this is the same edge on which the regfile commits.
  - If a set and a clear hit the same address on the same edge, set wins.
  - Issuing to an already-pending address is an upstream protocol violation; decode must stall it. Behaviour in that case is undefined except that the pending bit stays set.
- Stall (combinational):
  - stall = (rd_addr1 != 0 && pending[rd_addr1]) || (rd_addr2 != 0 && pending[rd_addr2]).
  - ALU results are not tracked by the scoreboard; the pipeline resolves ALU-to-ALU hazards upstream.
- Without the optional feature: byp_dataN = rf_dataN.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - byp_dataN = WriteData when RegWrite && WriteAddr == rd_addrN && rd_addrN != 0; otherwise byp_dataN = rf_dataN.
  - stall ignores an operand whose pending bit is being cleared by the current write (i.e. that operand matches WriteAddr with RegWrite = 1). This saves one stall cycle.
- Undefined: no forwarding; byp_dataN = rf_dataN, and stall uses only pending.

Test Plan:
- Reset and ALU write: reset_n low mid-write with FIFO count 3 and pending = 0x0000_0010 -> RegWrite = 0, WriteAddr = 0, WriteData = 0, lsu_ready = 0 while reset_n is low; lsu_ready = 1, FIFO empty and pending = 0 after release. Then alu_valid, alu_addr = 5, alu_data = 0xDEADBEEF -> next cycle RegWrite = 1, WriteAddr = 5, WriteData = 0xDEADBEEF. alu_addr = 0 -> RegWrite = 0.
- Arbitration: LSU push (addr 7, 0x11) while alu_valid is held for 3 cycles (addrs 1, 2, 3) -> port shows 1, 2, 3, then 7/0x11 on the first cycle alu_valid = 0.
- FIFO full: alu_valid held high, push 4 LSU entries -> lsu_ready = 0 after the 4th push; drop alu_valid -> entries emerge in push order, one per cycle, and lsu_ready returns to 1 after the first pop.
- Scoreboard: issue_addr = 9, rd_addr1 = 9 -> stall = 1 until the edge where RegWrite = 1 with WriteAddr = 9 (stall low on the following cycle, or during that cycle when REGFILE_WB_BYPASS_EN is defined, with byp_data1 = WriteData). issue to addr 0 -> no stall.
- Set/clear collision: RegWrite with WriteAddr = 12 on the same edge as issue_valid with issue_addr = 12 -> pending[12] remains 1 and stall stays high for rd_addr2 = 12.
